// File: rtl/wb_psram_arbiter.sv
// rtl/wb_psram_arbiter.sv - two-master Wishbone round-robin arbiter for the shared PSRAM controller port
// One transfer per registered grant; a watchdog terminates stuck transfers with ERR_DATA.
module wb_psram_arbiter #(
    parameter int              AW       = 32,
    parameter int              DW       = 32,
    parameter int              TIMEOUT  = 256,
    parameter logic [DW-1:0]   ERR_DATA = 32'hDEADBEEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,
    output logic [1:0]        gnt_o,
    output logic              tmo_o
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_owner, w_owner_nxt;
    logic            r_last, w_last_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;

    logic            w_req0, w_req1;
    logic            w_own_cyc, w_own_stb, w_own_we;
    logic [DW/8-1:0] w_own_sel;
    logic [AW-1:0]   w_own_adr;
    logic [DW-1:0]   w_own_dat, w_rdat;
    logic            w_busy, w_ack, w_tmo, w_rack;

    assign w_req0    = m0_cyc_i & m0_stb_i;
    assign w_req1    = m1_cyc_i & m1_stb_i;
    assign w_own_cyc = r_owner ? m1_cyc_i : m0_cyc_i;
    assign w_own_stb = r_owner ? m1_stb_i : m0_stb_i;
    assign w_own_we  = r_owner ? m1_we_i  : m0_we_i;
    assign w_own_sel = r_owner ? m1_sel_i : m0_sel_i;
    assign w_own_adr = r_owner ? m1_adr_i : m0_adr_i;
    assign w_own_dat = r_owner ? m1_dat_i : m0_dat_i;

    // Outputs are held quiet during reset so an abandoned transfer never sees an ack.
    assign w_busy = (r_state == ST_BUSY) && !wb_rst_i;
    assign w_ack  = w_busy && w_own_cyc && w_own_stb && s_ack_i;
    assign w_tmo  = (TIMEOUT != 0) && w_busy && w_own_cyc && !w_ack && (r_cnt == CNT_LAST);
    assign w_rack = w_tmo || (w_busy && w_own_cyc && s_ack_i);
    assign w_rdat = w_tmo ? ERR_DATA : s_dat_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 || w_req1) begin
                    w_state_nxt = ST_BUSY;
                    w_owner_nxt = (w_req0 && w_req1) ? ~r_last : w_req1;
                    w_cnt_nxt   = '0;
                end
            end
            ST_BUSY: begin
                if (!w_own_cyc || w_ack || w_tmo) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_owner;
                end else if (TIMEOUT != 0 && r_cnt != CNT_LAST) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_o    = 2'b00;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        tmo_o    = w_tmo;
        if (r_state == ST_BUSY) begin
            gnt_o = r_owner ? 2'b10 : 2'b01;
        end
        if (w_busy) begin
            s_cyc_o = w_own_cyc && !w_tmo;
            s_stb_o = w_own_cyc && w_own_stb && !w_tmo;
            s_we_o  = w_own_we;
            s_sel_o = w_own_sel;
            s_adr_o = w_own_adr;
            s_dat_o = w_own_dat;
            if (r_owner) begin
                m1_ack_o = w_rack;
                m1_dat_o = w_rdat;
            end else begin
                m0_ack_o = w_rack;
                m0_dat_o = w_rdat;
            end
        end
    end
endmodule

// File: tb/tb_wb_psram_arbiter.sv
// tb/tb_wb_psram_arbiter.sv - directed self-checking bench for wb_psram_arbiter
module tb_wb_psram_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [3:0]  m0_sel, m1_sel, s_sel;
    logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat, m0_rdat, m1_rdat;
    logic        m0_ack, m1_ack;
    logic        s_cyc, s_stb, s_we, s_ack, tmo;
    logic [31:0] s_adr, s_wdat, s_rdat;
    logic [1:0]  gnt;
    int          n_total = 0;
    int          n_bad   = 0;

    always #5 clk = ~clk;

    wb_psram_arbiter #(.AW(32), .DW(32), .TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack),
        .gnt_o(gnt), .tmo_o(tmo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic m0_req(input logic on, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        m0_cyc = on; m0_stb = on; m0_we = we; m0_sel = 4'hF; m0_adr = adr; m0_wdat = dat;
    endtask

    task automatic m1_req(input logic on, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        m1_cyc = on; m1_stb = on; m1_we = we; m1_sel = 4'h3; m1_adr = adr; m1_wdat = dat;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_ack = 1'b0; s_rdat = '0;
        m0_req(1'b0, 1'b0, '0, '0);
        m1_req(1'b0, 1'b0, '0, '0);
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        rst = 1'b1;
        sample();
        check("rst_gnt", gnt, 2'b00);
        check("rst_scyc", {s_cyc, s_stb, tmo, m0_ack, m1_ack}, 5'b0);
        tick();
        rst = 1'b0;

        // 1: single M0 write, slave acks in third BUSY cycle
        m0_req(1'b1, 1'b1, 32'h30040010, 32'hA5A5A5A5);
        sample();
        check("t1_c0_gnt", gnt, 2'b00);
        check("t1_c0_stb", s_stb, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            s_ack = (c == 3);
            sample();
            check("t1_gnt", gnt, 2'b01);
            check("t1_stb", s_stb, 1'b1);
            check("t1_adr", s_adr, 32'h30040010);
            check("t1_dat", s_wdat, 32'hA5A5A5A5);
            check("t1_ack", m0_ack, (c == 3));
        end
        tick();
        s_ack = 1'b0;
        m0_req(1'b0, 1'b0, '0, '0);
        sample();
        check("t1_c4_gnt", gnt, 2'b00);
        check("t1_c4_ack", m0_ack, 1'b0);

        // 2: simultaneous requests after reset, M0 first
        do_reset();
        m0_req(1'b1, 1'b0, 32'h100, '0);
        m1_req(1'b1, 1'b0, 32'h200, '0);
        tick();
        s_ack = 1'b1; s_rdat = 32'h11112222;
        sample();
        check("t2_gnt0", gnt, 2'b01);
        check("t2_adr0", s_adr, 32'h100);
        check("t2_ack0", {m0_ack, m1_ack}, 2'b10);
        check("t2_dat0", m0_rdat, 32'h11112222);
        check("t2_nodat1", m1_rdat, 32'h0);
        tick();
        s_ack = 1'b0;
        m0_req(1'b0, 1'b0, '0, '0);
        sample();
        check("t2_idle", gnt, 2'b00);
        tick();
        s_ack = 1'b1; s_rdat = 32'h33334444;
        sample();
        check("t2_gnt1", gnt, 2'b10);
        check("t2_sel1", s_sel, 4'h3);
        check("t2_ack1", {m0_ack, m1_ack}, 2'b01);
        check("t2_dat1", m1_rdat, 32'h33334444);
        tick();
        s_ack = 1'b0;
        m1_req(1'b0, 1'b0, '0, '0);

        // 3: continuous contention, grants alternate
        do_reset();
        m0_req(1'b1, 1'b1, 32'h10, 32'h1);
        m1_req(1'b1, 1'b1, 32'h20, 32'h2);
        for (int k = 0; k < 4; k++) begin
            sample();
            check("t3_idle", gnt, 2'b00);
            tick();
            sample();
            check("t3_gnt", gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            s_ack = 1'b1;
            sample();
            check("t3_acks", {m0_ack, m1_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            s_ack = 1'b0;
        end
        m0_req(1'b0, 1'b0, '0, '0);
        m1_req(1'b0, 1'b0, '0, '0);

        // 4: M1 read times out on the 16th BUSY cycle; pending M0 follows
        do_reset();
        m1_req(1'b1, 1'b0, 32'h400, '0);
        tick();
        m0_req(1'b1, 1'b0, 32'h500, '0);
        for (int c = 1; c <= 15; c++) begin
            sample();
            check("t4_pre", {gnt, tmo, m1_ack, m0_ack}, {2'b10, 3'b000});
            tick();
        end
        sample();
        check("t4_ack", m1_ack, 1'b1);
        check("t4_dat", m1_rdat, 32'hDEADBEEF);
        check("t4_tmo", tmo, 1'b1);
        check("t4_scyc", {s_cyc, s_stb}, 2'b00);
        check("t4_m0ack", m0_ack, 1'b0);
        tick();
        m1_req(1'b0, 1'b0, '0, '0);
        sample();
        check("t4_idle", {gnt, tmo}, 3'b000);
        tick();
        sample();
        check("t4_m0gnt", gnt, 2'b01);
        check("t4_m0adr", s_adr, 32'h500);
        tick();
        m0_req(1'b0, 1'b0, '0, '0);

        // 5: M0 aborts, waiting M1 granted; ack on timeout cycle wins
        do_reset();
        m0_req(1'b1, 1'b0, 32'h600, '0);
        m1_req(1'b1, 1'b1, 32'h700, 32'hCAFE0001);
        tick();
        sample();
        check("t5_gnt0", gnt, 2'b01);
        tick();
        m0_req(1'b0, 1'b0, '0, '0);
        sample();
        check("t5_abort", {s_cyc, s_stb, m0_ack}, 3'b000);
        tick();
        sample();
        check("t5_idle", gnt, 2'b00);
        for (int c = 1; c <= 16; c++) begin
            tick();
            s_ack = (c == 16); s_rdat = 32'h12345678;
            sample();
            check("t5_gnt1", gnt, 2'b10);
            check("t5_m1ack", m1_ack, (c == 16));
            check("t5_tmo", tmo, 1'b0);
        end
        check("t5_rdat", m1_rdat, 32'h12345678);
        check("t5_scyc", s_cyc, 1'b1);
        tick();
        s_ack = 1'b0;
        m1_req(1'b0, 1'b0, '0, '0);
        sample();
        check("t5_end", gnt, 2'b00);

        // 6: reset in the middle of a transfer
        do_reset();
        m0_req(1'b1, 1'b0, 32'h800, '0);
        tick();
        sample();
        check("t6_gnt", gnt, 2'b01);
        tick();
        rst = 1'b1; s_ack = 1'b1;
        m0_req(1'b0, 1'b0, '0, '0);
        sample();
        check("t6_rst_ack", {m0_ack, m1_ack}, 2'b00);
        tick();
        rst = 1'b0; s_ack = 1'b0;
        sample();
        check("t6_gnt_after", gnt, 2'b00);
        check("t6_ack_after", {m0_ack, m1_ack, s_cyc}, 3'b000);
        tick();
        s_ack = 1'b1;
        sample();
        check("t6_stray", {m0_ack, m1_ack, gnt}, 4'b0000);
        tick();
        s_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
